// File: rtl/tt_ctrl_sel_driver_pkg.sv
// Shared definitions for the Tiny Tapeout mux-control initiator: default widths
// and the FSM state encoding, so chip-side and board-side models agree.
package tt_ctrl_sel_driver_pkg;

  localparam int DEFAULT_ADDR_W  = 10;
  localparam int DEFAULT_PULSE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST_LO = 3'd1,
    ST_RST_HI = 3'd2,
    ST_INC_HI = 3'd3,
    ST_INC_LO = 3'd4,
    ST_FINISH = 3'd5
  } sel_state_t;

  // Phase timer width: must hold PULSE_W-1 and still be at least one bit wide.
  function automatic int timer_width(input int pulse_w);
    return (pulse_w < 2) ? 1 : $clog2(pulse_w + 1);
  endfunction

endpackage

// File: rtl/tt_ctrl_pulse_timer.sv
// Loadable down-counter used to time each pulse phase; tc is high on the last
// cycle of a phase (count has reached zero).
module tt_ctrl_pulse_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/tt_ctrl_sel_driver.sv
// Board-side initiator for the Tiny Tapeout mux controller: turns one address
// request into the sel_rst_n / sel_inc pulse train, then drives ctl_ena.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and req_valid is
// ignored at any other time (no queuing).
module tt_ctrl_sel_driver
  import tt_ctrl_sel_driver_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int PULSE_W = DEFAULT_PULSE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              busy,
  output logic              done,
  output logic              ctl_sel_rst_n,
  output logic              ctl_sel_inc,
  output logic              ctl_ena,
  output logic [2:0]        state
);

  localparam int CNT_W = timer_width(PULSE_W);
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PULSE_W - 1);

  sel_state_t        state_q, state_d;
  logic [ADDR_W-1:0] inc_left_q, inc_left_d;
  logic              ena_lat_q, ena_lat_d;
  logic              rst_n_d, inc_d, ena_d, busy_d, done_d, ready_d;
  logic              timer_load, timer_tc;

  tt_ctrl_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (PHASE_LOAD),
    .tc         (timer_tc)
  );

  // Every output is computed one cycle ahead here and registered below, so the
  // pads see glitch-free levels that change only on clock edges.
  always_comb begin
    state_d    = state_q;
    inc_left_d = inc_left_q;
    ena_lat_d  = ena_lat_q;
    rst_n_d    = ctl_sel_rst_n;
    inc_d      = ctl_sel_inc;
    ena_d      = ctl_ena;
    busy_d     = busy;
    done_d     = 1'b0;
    ready_d    = req_ready;
    timer_load = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          inc_left_d = req_addr;
          ena_lat_d  = req_ena;
          ena_d      = 1'b0;
          rst_n_d    = 1'b0;
          inc_d      = 1'b0;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
          timer_load = 1'b1;
          state_d    = ST_RST_LO;
        end
      end

      ST_RST_LO: begin
        if (timer_tc) begin
          rst_n_d    = 1'b1;
          timer_load = 1'b1;
          state_d    = ST_RST_HI;
        end
      end

      // Both "low" phases end with the same decision: another pulse or finish.
      ST_RST_HI, ST_INC_LO: begin
        if (timer_tc) begin
          if (inc_left_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ena_d   = ena_lat_q;
            state_d = ST_FINISH;
          end else begin
            inc_d      = 1'b1;
            timer_load = 1'b1;
            state_d    = ST_INC_HI;
          end
        end
      end

      ST_INC_HI: begin
        if (timer_tc) begin
          inc_d      = 1'b0;
          inc_left_d = inc_left_q - ADDR_W'(1);
          timer_load = 1'b1;
          state_d    = ST_INC_LO;
        end
      end

      ST_FINISH: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        inc_d   = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      inc_left_q    <= '0;
      ena_lat_q     <= 1'b0;
      ctl_sel_rst_n <= 1'b0;
      ctl_sel_inc   <= 1'b0;
      ctl_ena       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      req_ready     <= 1'b1;
    end else begin
      state_q       <= state_d;
      inc_left_q    <= inc_left_d;
      ena_lat_q     <= ena_lat_d;
      ctl_sel_rst_n <= rst_n_d;
      ctl_sel_inc   <= inc_d;
      ctl_ena       <= ena_d;
      busy          <= busy_d;
      done          <= done_d;
      req_ready     <= ready_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_tt_ctrl_sel_driver.sv
// Directed bench for tt_ctrl_sel_driver: one instance with PULSE_W=2 for the
// pulse-shape scenarios and one with PULSE_W=1 for the full-count address.
module tb_tt_ctrl_sel_driver;

  localparam int AW = 10;
  localparam int TR = 2200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          rv0, rr0, re0, busy0, done0, rn0, inc0, en0;
  logic [AW-1:0] ra0;
  logic [2:0]    st0;
  logic          rv1, rr1, re1, busy1, done1, rn1, inc1, en1;
  logic [AW-1:0] ra1;
  logic [2:0]    st1;

  tt_ctrl_sel_driver #(.ADDR_W(AW), .PULSE_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_addr(ra0),
    .req_ena(re0), .busy(busy0), .done(done0), .ctl_sel_rst_n(rn0),
    .ctl_sel_inc(inc0), .ctl_ena(en0), .state(st0)
  );

  tt_ctrl_sel_driver #(.ADDR_W(AW), .PULSE_W(1)) dut_fast (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .req_addr(ra1),
    .req_ena(re1), .busy(busy1), .done(done1), .ctl_sel_rst_n(rn1),
    .ctl_sel_inc(inc1), .ctl_ena(en1), .state(st1)
  );

  int checks = 0;
  int failures = 0;

  // Trace of one run, index k = cycle T+k after the accept edge T.
  logic tr_rst_n [0:TR-1];
  logic tr_inc   [0:TR-1];
  logic tr_ena   [0:TR-1];
  logic tr_done  [0:TR-1];
  logic tr_busy  [0:TR-1];
  logic tr_ready [0:TR-1];
  int   tr_len;

  task automatic drive(input int sel, input logic v, input logic [AW-1:0] a, input logic e);
    if (sel == 0) begin rv0 = v; ra0 = a; re0 = e; end
    else begin rv1 = v; ra1 = a; re1 = e; end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? rr0 : rr1;
  endfunction

  // Accept a request, then trace until the ndone-th done pulse plus extra cycles.
  // With hold set, req_valid stays high (with hold_addr) while the block is busy.
  task automatic run_seq(input int sel, input logic [AW-1:0] addr, input logic ena,
                         input bit hold, input logic [AW-1:0] hold_addr,
                         input int ndone, input int extra, input int budget);
    int w = 0;
    int done_seen = 0;
    int after = 0;
    @(negedge clk);
    while (get_ready(sel) !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    drive(sel, 1'b1, addr, ena);
    @(posedge clk);
    tr_len = 0;
    tr_inc[0] = 1'b0;
    tr_rst_n[0] = 1'b1;
    for (int k = 1; k < budget && k < TR; k++) begin
      @(negedge clk);
      if (sel == 0) begin
        tr_rst_n[k] = rn0; tr_inc[k] = inc0; tr_ena[k] = en0;
        tr_done[k] = done0; tr_busy[k] = busy0; tr_ready[k] = rr0;
      end else begin
        tr_rst_n[k] = rn1; tr_inc[k] = inc1; tr_ena[k] = en1;
        tr_done[k] = done1; tr_busy[k] = busy1; tr_ready[k] = rr1;
      end
      tr_len = k;
      if (k == 1) drive(sel, hold, hold ? hold_addr : addr, ena);
      if (tr_done[k] === 1'b1) done_seen++;
      if (done_seen >= ndone) begin
        drive(sel, 1'b0, '0, 1'b0);
        if (after >= extra) break;
        after++;
      end
    end
    drive(sel, 1'b0, '0, 1'b0);
  endtask

  function automatic int done_at(input int n);
    int c = 0;
    for (int k = 1; k <= tr_len; k++) if (tr_done[k] === 1'b1) begin c++; if (c == n) return k; end
    return -1;
  endfunction

  function automatic int count_inc(input int from, input int to);
    int c = 0;
    for (int k = from; k <= to && k <= tr_len; k++) if (tr_inc[k] === 1'b1 && tr_inc[k-1] !== 1'b1) c++;
    return c;
  endfunction

  function automatic int inc_start(input int n);
    int c = 0;
    for (int k = 1; k <= tr_len; k++) if (tr_inc[k] === 1'b1 && tr_inc[k-1] !== 1'b1) begin c++; if (c == n) return k; end
    return -1;
  endfunction

  function automatic int count_high(input int which, input int from, input int to);
    int c = 0;
    for (int k = from; k <= to && k <= tr_len; k++) begin
      if (which == 0 && tr_inc[k] === 1'b1) c++;
      if (which == 1 && tr_ena[k] === 1'b1) c++;
      if (which == 2 && tr_rst_n[k] === 1'b0) c++;
      if (which == 3 && tr_ready[k] === 1'b1) c++;
    end
    return c;
  endfunction

  function automatic int overlap();
    int c = 0;
    for (int k = 1; k <= tr_len; k++) if (tr_inc[k] === 1'b1 && tr_rst_n[k] !== 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rr0 !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", rr0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done0); end
    checks++; if (rn0 !== 1'b0) begin failures++; $display("FAIL reset_sel_rst_n: got %b expected 0", rn0); end
    checks++; if (inc0 !== 1'b0) begin failures++; $display("FAIL reset_sel_inc: got %b expected 0", inc0); end
    checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL reset_ena: got %b expected 0", en0); end
    checks++; if (rr1 !== 1'b1 || rn1 !== 1'b0) begin failures++; $display("FAIL reset_fast: got ready=%b rst_n=%b expected 1 0", rr1, rn1); end
    repeat (3) @(negedge clk);
    checks++; if (rn0 !== 1'b0) begin failures++; $display("FAIL idle_rst_n_held: got %b expected 0", rn0); end
  endtask

  task automatic test_addr3;
    run_seq(0, 10'd3, 1'b1, 1'b0, '0, 1, 2, 60);
    checks++; if (done_at(1) !== 17) begin failures++; $display("FAIL a3_done_cycle: got %0d expected 17", done_at(1)); end
    checks++; if (tr_rst_n[1] !== 1'b0 || tr_rst_n[2] !== 1'b0 || tr_rst_n[3] !== 1'b1) begin failures++; $display("FAIL a3_rst_window: got %b%b%b expected 001", tr_rst_n[1], tr_rst_n[2], tr_rst_n[3]); end
    checks++; if (count_high(2, 1, 17) !== 2) begin failures++; $display("FAIL a3_rst_low_len: got %0d expected 2", count_high(2, 1, 17)); end
    checks++; if (inc_start(1) !== 5) begin failures++; $display("FAIL a3_inc1_start: got %0d expected 5", inc_start(1)); end
    checks++; if (inc_start(2) !== 9) begin failures++; $display("FAIL a3_inc2_start: got %0d expected 9", inc_start(2)); end
    checks++; if (inc_start(3) !== 13) begin failures++; $display("FAIL a3_inc3_start: got %0d expected 13", inc_start(3)); end
    checks++; if (count_inc(1, 19) !== 3) begin failures++; $display("FAIL a3_inc_count: got %0d expected 3", count_inc(1, 19)); end
    checks++; if (count_high(0, 1, 19) !== 6) begin failures++; $display("FAIL a3_inc_high_cycles: got %0d expected 6", count_high(0, 1, 19)); end
    checks++; if (count_high(1, 1, 16) !== 0) begin failures++; $display("FAIL a3_ena_during_seq: got %0d expected 0", count_high(1, 1, 16)); end
    checks++; if (tr_ena[17] !== 1'b1) begin failures++; $display("FAIL a3_ena_at_done: got %b expected 1", tr_ena[17]); end
    checks++; if (tr_busy[1] !== 1'b1 || tr_busy[16] !== 1'b1 || tr_busy[17] !== 1'b0) begin failures++; $display("FAIL a3_busy: got %b%b%b expected 110", tr_busy[1], tr_busy[16], tr_busy[17]); end
    checks++; if (tr_ready[17] !== 1'b0 || tr_ready[18] !== 1'b1) begin failures++; $display("FAIL a3_ready_return: got %b%b expected 01", tr_ready[17], tr_ready[18]); end
    checks++; if (tr_done[18] !== 1'b0) begin failures++; $display("FAIL a3_done_width: got %b expected 0", tr_done[18]); end
    checks++; if (tr_rst_n[19] !== 1'b1 || tr_ena[19] !== 1'b1) begin failures++; $display("FAIL a3_idle_hold: got rst_n=%b ena=%b expected 1 1", tr_rst_n[19], tr_ena[19]); end
    checks++; if (overlap() !== 0) begin failures++; $display("FAIL a3_inc_under_rst: got %0d expected 0", overlap()); end
  endtask

  task automatic test_addr0;
    run_seq(0, 10'd0, 1'b1, 1'b0, '0, 1, 1, 40);
    checks++; if (done_at(1) !== 5) begin failures++; $display("FAIL a0_done_cycle: got %0d expected 5", done_at(1)); end
    checks++; if (count_inc(1, 6) !== 0) begin failures++; $display("FAIL a0_inc_count: got %0d expected 0", count_inc(1, 6)); end
    checks++; if (tr_ena[1] !== 1'b0 || tr_ena[5] !== 1'b1) begin failures++; $display("FAIL a0_ena: got %b%b expected 01", tr_ena[1], tr_ena[5]); end
    checks++; if (tr_rst_n[2] !== 1'b0 || tr_rst_n[3] !== 1'b1) begin failures++; $display("FAIL a0_rst_window: got %b%b expected 01", tr_rst_n[2], tr_rst_n[3]); end
  endtask

  task automatic test_ena_off;
    run_seq(0, 10'd5, 1'b0, 1'b0, '0, 1, 1, 60);
    checks++; if (done_at(1) !== 25) begin failures++; $display("FAIL e0_done_cycle: got %0d expected 25", done_at(1)); end
    checks++; if (count_inc(1, 26) !== 5) begin failures++; $display("FAIL e0_inc_count: got %0d expected 5", count_inc(1, 26)); end
    checks++; if (inc_start(5) !== 21) begin failures++; $display("FAIL e0_inc5_start: got %0d expected 21", inc_start(5)); end
    checks++; if (tr_ena[25] !== 1'b0 || tr_ena[26] !== 1'b0) begin failures++; $display("FAIL e0_ena_stays_low: got %b%b expected 00", tr_ena[25], tr_ena[26]); end
  endtask

  task automatic test_back_to_back;
    run_seq(0, 10'd2, 1'b1, 1'b1, 10'd1, 2, 1, 80);
    checks++; if (done_at(1) !== 13) begin failures++; $display("FAIL b2b_first_done: got %0d expected 13", done_at(1)); end
    checks++; if (count_inc(1, 13) !== 2) begin failures++; $display("FAIL b2b_first_incs: got %0d expected 2", count_inc(1, 13)); end
    checks++; if (count_high(3, 1, 13) !== 0) begin failures++; $display("FAIL b2b_ready_while_busy: got %0d expected 0", count_high(3, 1, 13)); end
    checks++; if (tr_ready[14] !== 1'b1 || tr_busy[14] !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: got ready=%b busy=%b expected 1 0", tr_ready[14], tr_busy[14]); end
    checks++; if (tr_busy[15] !== 1'b1 || tr_rst_n[15] !== 1'b0) begin failures++; $display("FAIL b2b_second_accept: got busy=%b rst_n=%b expected 1 0", tr_busy[15], tr_rst_n[15]); end
    checks++; if (done_at(2) !== 23) begin failures++; $display("FAIL b2b_second_done: got %0d expected 23", done_at(2)); end
    checks++; if (count_inc(14, 24) !== 1) begin failures++; $display("FAIL b2b_second_incs: got %0d expected 1", count_inc(14, 24)); end
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    int busies = 0;
    @(negedge clk);
    while (rr0 !== 1'b1 && dones < 200) begin @(negedge clk); dones++; end
    dones = 0;
    drive(0, 1'b1, 10'd4, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (inc0 !== 1'b1) begin failures++; $display("FAIL abort_in_inc_hi: got %b expected 1", inc0); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rn0 !== 1'b0 || inc0 !== 1'b0 || en0 !== 1'b0) begin failures++; $display("FAIL abort_pads: got rst_n=%b inc=%b ena=%b expected 0 0 0", rn0, inc0, en0); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || rr0 !== 1'b1) begin failures++; $display("FAIL abort_status: got busy=%b done=%b ready=%b expected 0 0 1", busy0, done0, rr0); end
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done0 === 1'b1) dones++;
      if (busy0 === 1'b1) busies++;
    end
    checks++; if (dones !== 0 || busies !== 0) begin failures++; $display("FAIL abort_no_done: got done=%0d busy=%0d expected 0 0", dones, busies); end
    run_seq(0, 10'd2, 1'b1, 1'b0, '0, 1, 1, 60);
    checks++; if (done_at(1) !== 13) begin failures++; $display("FAIL abort_rerun_done: got %0d expected 13", done_at(1)); end
    checks++; if (count_inc(1, 14) !== 2) begin failures++; $display("FAIL abort_rerun_incs: got %0d expected 2", count_inc(1, 14)); end
    checks++; if (tr_ena[13] !== 1'b1) begin failures++; $display("FAIL abort_rerun_ena: got %b expected 1", tr_ena[13]); end
  endtask

  task automatic test_full_count;
    run_seq(1, 10'd1023, 1'b1, 1'b0, '0, 1, 1, 2100);
    checks++; if (done_at(1) !== 2049) begin failures++; $display("FAIL full_done_cycle: got %0d expected 2049", done_at(1)); end
    checks++; if (count_inc(1, 2050) !== 1023) begin failures++; $display("FAIL full_inc_count: got %0d expected 1023", count_inc(1, 2050)); end
    checks++; if (tr_rst_n[1] !== 1'b0 || tr_rst_n[2] !== 1'b1 || tr_inc[3] !== 1'b1) begin failures++; $display("FAIL full_first_pulse: got rst_n=%b%b inc=%b expected 01 1", tr_rst_n[1], tr_rst_n[2], tr_inc[3]); end
    checks++; if (tr_ena[2049] !== 1'b1) begin failures++; $display("FAIL full_ena: got %b expected 1", tr_ena[2049]); end
    checks++; if (overlap() !== 0) begin failures++; $display("FAIL full_inc_under_rst: got %0d expected 0", overlap()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addr3();
    test_addr0();
    test_ena_off();
    test_back_to_back();
    test_reset_abort();
    test_full_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
